// File: rtl/sched_pkg.sv
// Shared types for the multicore job scheduler: FSM states, descriptor widths
// and the packed tile-job descriptor carried through the job FIFO.
package sched_pkg;

    localparam int unsigned GEOM_W         = 16;
    localparam int unsigned DEF_POF        = 2;
    localparam int unsigned DEF_PIF        = 3;
    localparam int unsigned DEF_MULT_WIDTH = 16;
    localparam int unsigned MULTS_W        = DEF_POF * DEF_PIF * DEF_MULT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic                is_dfconv;
        logic                last;
        logic [GEOM_W-1:0]   rows;
        logic [GEOM_W-1:0]   cols;
        logic [GEOM_W-1:0]   in_ch;
        logic [GEOM_W-1:0]   out_ch;
        logic [MULTS_W-1:0]  mults;
    } job_desc_t;

endpackage

// File: rtl/sched_job_fifo.sv
// Synchronous job-descriptor FIFO with full/empty flags; push and pop may
// coincide, including while full.
module sched_job_fifo
    import sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  job_desc_t wdata,
    output job_desc_t rdata_c,
    output logic      full,
    output logic      empty,
    output logic      full_next_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    job_desc_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              do_push;
    logic              do_pop;

    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);
    assign count_next  = count + CW'(do_push) - CW'(do_pop);
    assign full_next_c = (count_next == CW'(DEPTH));
    assign rdata_c     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= full_next_c;
            empty <= (count_next == '0);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/multicore_job_scheduler.sv
// Queued round-robin dispatcher of tile jobs to per-core SFTM/DfConv units.
// Optional SCHED_PERF_CNT_EN adds dispatch and stall performance counters.
module multicore_job_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 2,
    parameter int unsigned POF         = 2,
    parameter int unsigned PIF         = 3,
    parameter int unsigned MULT_WIDTH  = 16,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              job_valid,
    output logic                              job_ready,
    input  logic                              job_is_dfconv,
    input  logic                              job_last,
    input  logic [15:0]                       job_rows,
    input  logic [15:0]                       job_cols,
    input  logic [15:0]                       job_in_ch,
    input  logic [15:0]                       job_out_ch,
    input  logic [POF*PIF*MULT_WIDTH-1:0]     job_mults_flat,
    input  logic [NUM_CORES-1:0]              sftm_idle,
    input  logic [NUM_CORES-1:0]              dfconv_idle,
    input  logic [NUM_CORES-1:0]              sftm_done,
    input  logic [NUM_CORES-1:0]              dfconv_done,
    output logic [NUM_CORES-1:0]              sftm_start,
    output logic [NUM_CORES-1:0]              dfconv_start,
    output logic [15:0]                       disp_rows,
    output logic [15:0]                       disp_cols,
    output logic [15:0]                       disp_in_ch,
    output logic [15:0]                       disp_out_ch,
    output logic [POF*PIF*MULT_WIDTH-1:0]     disp_mults_flat,
    output logic [$clog2(2*NUM_CORES):0]      active_jobs,
    output logic                              busy,
    output logic                              done,
    output logic                              err_spurious_done
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_dispatched,
    output logic [31:0]                       perf_stall
`endif
);

    localparam int unsigned MW    = POF * PIF * MULT_WIDTH;
    localparam int unsigned AJ_W  = $clog2(2 * NUM_CORES) + 1;
    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    sched_state_t           state, state_next;
    logic                   busy_next, done_next, ready_next;
    logic [NUM_CORES-1:0]   res_s, res_d, res_s_next, res_d_next;
    logic [NUM_CORES-1:0]   set_s, set_d, free_mask, pick_onehot;
    logic [PTR_W-1:0]       rr_ptr, pick;
    logic                   found, dispatch, accept;
    logic                   fifo_full, fifo_empty, fifo_full_next;
    job_desc_t              in_desc, head;
    logic                   head_last_unused;

    assign accept  = job_valid && job_ready;
    assign in_desc = '{is_dfconv: job_is_dfconv, last: job_last,
                       rows: job_rows, cols: job_cols,
                       in_ch: job_in_ch, out_ch: job_out_ch,
                       mults: MULTS_W'(job_mults_flat)};
    assign head_last_unused = head.last;

    sched_job_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (accept),
        .pop         (dispatch),
        .wdata       (in_desc),
        .rdata_c     (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .full_next_c (fifo_full_next)
    );

    // Freeness uses registered reserve bits, so a unit finishing this cycle is not reused yet.
    assign free_mask = head.is_dfconv ? (~res_d & dfconv_idle) : (~res_s & sftm_idle);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!found && free_mask[PTR_W'(idx)]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    assign dispatch    = !fifo_empty && found;
    assign pick_onehot = NUM_CORES'(1) << pick;
    assign set_s       = (dispatch && !head.is_dfconv) ? pick_onehot : '0;
    assign set_d       = (dispatch &&  head.is_dfconv) ? pick_onehot : '0;
    assign res_s_next  = (res_s & ~sftm_done)   | set_s;
    assign res_d_next  = (res_d & ~dfconv_done) | set_d;

    always_comb begin
        state_next = state;
        busy_next  = busy;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    busy_next  = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept && job_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty && (res_s == '0) && (res_d == '0)) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        ready_next = (state_next == ST_RUN) && !fifo_full_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            job_ready         <= 1'b0;
            res_s             <= '0;
            res_d             <= '0;
            rr_ptr            <= '0;
            sftm_start        <= '0;
            dfconv_start      <= '0;
            active_jobs       <= '0;
            err_spurious_done <= 1'b0;
            disp_rows         <= '0;
            disp_cols         <= '0;
            disp_in_ch        <= '0;
            disp_out_ch       <= '0;
            disp_mults_flat   <= '0;
        end else begin
            state             <= state_next;
            busy              <= busy_next;
            done              <= done_next;
            job_ready         <= ready_next;
            res_s             <= res_s_next;
            res_d             <= res_d_next;
            sftm_start        <= set_s;
            dfconv_start      <= set_d;
            active_jobs       <= AJ_W'($countones({res_s_next, res_d_next}));
            err_spurious_done <= err_spurious_done
                                 | (|(sftm_done & ~res_s))
                                 | (|(dfconv_done & ~res_d));
            if (dispatch) begin
                rr_ptr          <= (32'(pick) == NUM_CORES - 1) ? '0 : pick + PTR_W'(1);
                disp_rows       <= head.rows;
                disp_cols       <= head.cols;
                disp_in_ch      <= head.in_ch;
                disp_out_ch     <= head.out_ch;
                disp_mults_flat <= MW'(head.mults);
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    // Saturating counters, cleared when a new batch is armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dispatched <= '0;
            perf_stall      <= '0;
        end else if (state == ST_IDLE && start) begin
            perf_dispatched <= '0;
            perf_stall      <= '0;
        end else begin
            if (dispatch && perf_dispatched != '1)
                perf_dispatched <= perf_dispatched + 32'd1;
            if (!fifo_empty && !found && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicore_job_scheduler.sv
// Self-checking bench for multicore_job_scheduler: queue-based reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_multicore_job_scheduler;

    localparam int NC = 2;
    localparam int QD = 4;

    typedef struct packed {
        logic        dfc;
        logic        last;
        logic [15:0] r;
        logic [15:0] c;
        logic [15:0] ic;
        logic [15:0] oc;
        logic [95:0] m;
    } job_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic        job_is_dfconv = 1'b0;
    logic        job_last = 1'b0;
    logic [15:0] job_rows = '0, job_cols = '0, job_in_ch = '0, job_out_ch = '0;
    logic [95:0] job_mults_flat = '0;
    logic [1:0]  sftm_idle = 2'b11, dfconv_idle = 2'b11;
    logic [1:0]  sftm_done = 2'b00, dfconv_done = 2'b00;
    logic [1:0]  sftm_start, dfconv_start;
    logic [15:0] disp_rows, disp_cols, disp_in_ch, disp_out_ch;
    logic [95:0] disp_mults_flat;
    logic [2:0]  active_jobs;
    logic        busy, done, err;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_dispatched, perf_stall;
`endif

    multicore_job_scheduler dut (
        .clk(clk), .rst(rst), .start(start),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_is_dfconv(job_is_dfconv), .job_last(job_last),
        .job_rows(job_rows), .job_cols(job_cols),
        .job_in_ch(job_in_ch), .job_out_ch(job_out_ch),
        .job_mults_flat(job_mults_flat),
        .sftm_idle(sftm_idle), .dfconv_idle(dfconv_idle),
        .sftm_done(sftm_done), .dfconv_done(dfconv_done),
        .sftm_start(sftm_start), .dfconv_start(dfconv_start),
        .disp_rows(disp_rows), .disp_cols(disp_cols),
        .disp_in_ch(disp_in_ch), .disp_out_ch(disp_out_ch),
        .disp_mults_flat(disp_mults_flat),
        .active_jobs(active_jobs), .busy(busy), .done(done),
`ifdef SCHED_PERF_CNT_EN
        .perf_dispatched(perf_dispatched), .perf_stall(perf_stall),
`endif
        .err_spurious_done(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    job_t        q[$];
    int          m_state = 0;        // 0 idle, 1 accepting, 2 draining
    logic [1:0]  m_rs = '0, m_rd = '0;
    int          m_rr = 0;
    logic [1:0]  e_ss = '0, e_ds = '0;
    job_t        e_disp = '0;
    int          e_act = 0;
    logic        e_busy = 0, e_done = 0, e_ready = 0, e_err = 0;
    logic [31:0] e_pd = '0, e_ps = '0;

    task automatic model_step();
        logic [1:0] ns, nd;
        bit found, popped, acc, drain_ok;
        int ch, i;
        job_t nj;
        ns = '0; nd = '0; found = 0; popped = 0; ch = 0;
        for (int u = 0; u < NC; u++) begin
            if (sftm_done[u] && !m_rs[u]) e_err = 1'b1;
            if (dfconv_done[u] && !m_rd[u]) e_err = 1'b1;
        end
        drain_ok = (q.size() == 0) && (m_rs == 0) && (m_rd == 0);
        acc = job_valid && e_ready;
        if (q.size() > 0) begin
            for (int k = 0; k < NC; k++) begin
                i = (m_rr + k) % NC;
                if (!found && (q[0].dfc ? (!m_rd[i] && dfconv_idle[i]) : (!m_rs[i] && sftm_idle[i]))) begin
                    found = 1; ch = i;
                end
            end
            if (found) begin
                if (q[0].dfc) nd[ch] = 1'b1; else ns[ch] = 1'b1;
                e_disp = q[0];
                m_rr = (ch + 1) % NC;
                popped = 1;
                if (e_pd != '1) e_pd = e_pd + 1;
            end else if (e_ps != '1) e_ps = e_ps + 1;
        end
        if (popped) void'(q.pop_front());
        if (acc) begin
            nj = '{dfc: job_is_dfconv, last: job_last, r: job_rows, c: job_cols,
                   ic: job_in_ch, oc: job_out_ch, m: job_mults_flat};
            q.push_back(nj);
        end
        m_rs = (m_rs & ~sftm_done) | ns;
        m_rd = (m_rd & ~dfconv_done) | nd;
        e_ss = ns; e_ds = nd; e_done = 1'b0;
        e_act = $countones({m_rs, m_rd});
        case (m_state)
            0: if (start) begin m_state = 1; e_busy = 1'b1; e_pd = '0; e_ps = '0; end
            1: if (acc && job_last) m_state = 2;
            default: if (drain_ok) begin m_state = 0; e_busy = 1'b0; e_done = 1'b1; end
        endcase
        e_ready = (m_state == 1) && (q.size() < QD);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_state = 0; m_rs = '0; m_rd = '0; m_rr = 0;
            e_ss = '0; e_ds = '0; e_disp = '0; e_act = 0;
            e_busy = 0; e_done = 0; e_ready = 0; e_err = 0; e_pd = '0; e_ps = '0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        chk("sftm_start", sftm_start, e_ss);
        chk("dfconv_start", dfconv_start, e_ds);
        chk("disp_rows", disp_rows, e_disp.r);
        chk("disp_cols", disp_cols, e_disp.c);
        chk("disp_in_ch", disp_in_ch, e_disp.ic);
        chk("disp_out_ch", disp_out_ch, e_disp.oc);
        chk("disp_mults", disp_mults_flat, e_disp.m);
        chk("active_jobs", active_jobs, e_act);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("job_ready", job_ready, e_ready);
        chk("err_spurious", err, e_err);
`ifdef SCHED_PERF_CNT_EN
        chk("perf_dispatched", perf_dispatched, e_pd);
        chk("perf_stall", perf_stall, e_ps);
`endif
    end

    // ---------------- stimulus helpers ----------------
    int cyc_n = 0, cnt_s0 = 0, cnt_s1 = 0, cnt_d = 0, done_cnt = 0, max_act = 0;
    int last_start_cyc = 0, last_done_cyc = 0, offer_cyc = 0;
    int s_cnt[NC] = '{0, 0}, d_cnt[NC] = '{0, 0};
    bit auto_en = 0;
    int lat = 2;

    // One cycle: sample at the falling edge, then act as the cores.
    task automatic cyc();
        logic [1:0] sd, dd;
        @(negedge clk);
        cyc_n++;
        if (sftm_start[0]) cnt_s0++;
        if (sftm_start[1]) cnt_s1++;
        if (dfconv_start != 0) cnt_d++;
        if (sftm_start != 0 || dfconv_start != 0) last_start_cyc = cyc_n;
        if (done) begin done_cnt++; last_done_cyc = cyc_n; end
        if (int'(active_jobs) > max_act) max_act = int'(active_jobs);
        sd = '0; dd = '0;
        for (int u = 0; u < NC; u++) begin
            if (s_cnt[u] > 0) begin s_cnt[u]--; if (s_cnt[u] == 0) sd[u] = 1'b1; end
            if (d_cnt[u] > 0) begin d_cnt[u]--; if (d_cnt[u] == 0) dd[u] = 1'b1; end
            if (auto_en && sftm_start[u]) s_cnt[u] = lat;
            if (auto_en && dfconv_start[u]) d_cnt[u] = lat;
        end
        sftm_done = sd;
        dfconv_done = dd;
    endtask

    task automatic clr_mon();
        cnt_s0 = 0; cnt_s1 = 0; cnt_d = 0; done_cnt = 0; max_act = 0;
    endtask

    task automatic offer(input bit dfc, input bit last, input int tag);
        int t;
        t = 0;
        while (!job_ready && t < 300) begin cyc(); t++; end
        chk("offer_ready", job_ready, 1'b1);
        offer_cyc = cyc_n;
        job_valid = 1'b1; job_is_dfconv = dfc; job_last = last;
        job_rows = 16'(tag * 4 + 1); job_cols = 16'(tag * 4 + 2);
        job_in_ch = 16'(tag + 3); job_out_ch = 16'(tag + 7);
        job_mults_flat = {6{16'(tag * 257 + 5)}};
        cyc();
        job_valid = 1'b0; job_last = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 300) begin cyc(); t++; end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic arm();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("arm_busy", busy, 1'b1);
        chk("arm_ready", job_ready, 1'b1);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", job_ready, 1'b0);
        chk("rst_active", active_jobs, 3'd0);
        rst = 1'b0;
        cyc();

        // Single SFTM job: start two cycles after offer, done after retirement.
        clr_mon(); auto_en = 1; lat = 5;
        arm();
        offer(1'b0, 1'b1, 1);
        wait_done();
        chk("t1_start_lat", last_start_cyc - offer_cyc, 2);
        chk("t1_done_lat", last_done_cyc - last_start_cyc, 7);
        chk("t1_core0", cnt_s0, 1);
        chk("t1_busy_low", busy, 1'b0);
        chk("t1_rows", disp_rows, 16'd5);
        cyc();

        // Core 0 held busy: four jobs serialised on core 1.
        clr_mon(); sftm_idle = 2'b10; lat = 3;
        arm();
        for (int j = 0; j < 4; j++) offer(1'b0, j == 3, 10 + j);
        wait_done();
        chk("t2_core0", cnt_s0, 0);
        chk("t2_core1", cnt_s1, 4);
        chk("t2_max_active", max_act, 1);
        chk("t2_last_rows", disp_rows, 16'd53);
        cyc();

        // DfConv head blocked: SFTM job behind it must not overtake.
        clr_mon(); sftm_idle = 2'b11; dfconv_idle = 2'b00; lat = 2;
        arm();
        offer(1'b1, 1'b0, 20);
        offer(1'b0, 1'b1, 21);
        repeat (4) cyc();
        chk("t3_no_sftm", cnt_s0 + cnt_s1, 0);
        chk("t3_no_dfc", cnt_d, 0);
`ifdef SCHED_PERF_CNT_EN
        chk("t3_perf_stall", perf_stall, 32'd5);
`endif
        dfconv_idle = 2'b11;
        wait_done();
        chk("t3_dfc", cnt_d, 1);
        chk("t3_sftm", cnt_s0 + cnt_s1, 1);
`ifdef SCHED_PERF_CNT_EN
        chk("t3_perf_disp", perf_dispatched, 32'd2);
`endif
        cyc();

        // FIFO full: one retirement frees a slot one cycle after dispatch.
        clr_mon(); auto_en = 0; sftm_idle = 2'b01; dfconv_idle = 2'b00;
        arm();
        for (int j = 0; j < 5; j++) offer(1'b0, 1'b0, 30 + j);
        chk("t4_full_ready", job_ready, 1'b0);
        repeat (2) cyc();
        chk("t4_active", active_jobs, 3'd1);
        chk("t4_still_full", job_ready, 1'b0);
        auto_en = 1; lat = 2;
        sftm_done[0] = 1'b1;
        cyc();
        chk("t4_ready_before", job_ready, 1'b0);
        chk("t4_no_start_yet", sftm_start, 2'b00);
        cyc();
        chk("t4_start", sftm_start, 2'b01);
        chk("t4_ready_after", job_ready, 1'b1);
        chk("t4_rows", disp_rows, 16'd125);
        offer(1'b0, 1'b1, 35);
        wait_done();
        cyc();

        // Both cores retire in the same cycle.
        clr_mon(); auto_en = 0; sftm_idle = 2'b11;
        arm();
        offer(1'b0, 1'b0, 40);
        offer(1'b0, 1'b1, 41);
        repeat (2) cyc();
        chk("t5_active2", active_jobs, 3'd2);
        chk("t5_split", cnt_s0 * 10 + cnt_s1, 11);
        sftm_done = 2'b11;
        cyc();
        chk("t5_active0", active_jobs, 3'd0);
        done_cnt = 0;
        repeat (4) cyc();
        chk("t5_done_once", done_cnt, 1);
        chk("t5_busy", busy, 1'b0);

        // Spurious completion, then reset in the middle of a batch.
        sftm_done[1] = 1'b1;
        cyc();
        chk("t6_err_set", err, 1'b1);
        repeat (3) cyc();
        chk("t6_err_sticky", err, 1'b1);
        sftm_idle = 2'b00;
        arm();
        offer(1'b0, 1'b0, 50);
        cyc();
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_ready", job_ready, 1'b0);
        chk("t6_rst_err", err, 1'b0);
        chk("t6_rst_active", active_jobs, 3'd0);
        chk("t6_rst_rows", disp_rows, 16'd0);
        chk("t6_rst_start", {sftm_start, dfconv_start}, 4'd0);
        repeat (2) cyc();
        rst = 1'b0;
        repeat (2) cyc();
        chk("t6_post_busy", busy, 1'b0);
        chk("t6_post_active", active_jobs, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
